// File: rtl/sdram_wr_fetch_if.sv
// Bundle of the FIFO read port, arbiter handshake and write-data stream
// that surround the SDRAM write-fetch block.
interface sdram_wr_fetch_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 22
);
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_ren;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_len;
  logic              wr_data_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_valid;

  // fetch block side
  modport master (
    input  fifo_dout, fifo_empty, fifo_count, wr_ack, wr_data_req,
    output fifo_ren, wr_req, wr_addr, wr_len, wr_data, wr_data_valid
  );

  // FIFO / arbiter / controller side
  modport slave (
    output fifo_dout, fifo_empty, fifo_count, wr_ack, wr_data_req,
    input  fifo_ren, wr_req, wr_addr, wr_len, wr_data, wr_data_valid
  );
endinterface

// File: rtl/sdram_wr_fetch.sv
// SDRAM write fetch: watches the write FIFO fill level, requests bursts from
// the arbiter, pops one burst of words into the controller's write-data path
// and advances a circular write address. A flush drains a partial burst.
//
// state  | meaning
// IDLE   | wait for a full burst in the FIFO or a pending flush
// REQ    | wr_req held high until the arbiter grants
// XFER   | pop one word per controller request until the burst is done
// LAST   | final word goes out; advance and wrap the write address
// SETTLE | two cycles for the lagging fifo_count to catch up with the pops
module sdram_wr_fetch #(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 10,
  parameter int BURST_LEN    = 8,
  parameter int ADDR_W       = 22,
  parameter int ADDR_BASE    = 0,
  parameter int REGION_WORDS = 4096
) (
  input  logic clk,
  input  logic rst,
  sdram_wr_fetch_if.master bus,
  input  logic flush,
  output logic flush_done,
  output logic busy,
  output logic underrun
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, LAST, SETTLE} state_t;

  localparam logic [CNT_W-1:0]  BURST_C  = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W:0]   END_A    = (ADDR_W+1)'(ADDR_BASE + REGION_WORDS);
  localparam logic [ADDR_W:0]   REGION_A = (ADDR_W+1)'(REGION_WORDS);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  remaining;
  logic              settle_cnt;
  logic              flush_pend;
  logic              req_q;
  logic              valid_q;
  logic              done_q;
  logic              underrun_q;
  logic              ren;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W:0]   addr_next;
  logic [DATA_W-1:0] data;

  // Pop strobe; forced low while reset is asserted so nothing is lost mid-burst.
  always_comb begin
    ren = !rst && (state == XFER) && bus.wr_data_req &&
          (remaining != '0) && !bus.fifo_empty;
  end

  // Next burst address, computed one bit wider so the wrap compare cannot overflow.
  always_comb begin
    addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(len_q);
    addr_next = addr_sum;
    if (addr_sum >= END_A) addr_next = addr_sum - REGION_A;
  end

  // Sequencer, address/length registers, data-valid delay and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= BASE_A;
      len_q      <= '0;
      remaining  <= '0;
      settle_cnt <= 1'b0;
      flush_pend <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      valid_q <= ren;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fifo_count >= BURST_C) begin
            len_q <= BURST_C;
            req_q <= 1'b1;
            state <= REQ;
          end else if (flush_pend && bus.fifo_count != '0) begin
            len_q <= bus.fifo_count;
            req_q <= 1'b1;
            state <= REQ;
          end else if (flush_pend && bus.fifo_empty) begin
            flush_pend <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        REQ: begin
          if (bus.wr_ack) begin
            req_q     <= 1'b0;
            remaining <= len_q;
            state     <= XFER;
          end
        end
        XFER: begin
          if (ren) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= LAST;
          end
          if (bus.wr_data_req && remaining != '0 && bus.fifo_empty) underrun_q <= 1'b1;
        end
        LAST: begin
          addr_q     <= addr_next[ADDR_W-1:0];
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt) state <= IDLE;
          else settle_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // a new flush pulse wins over the clear, so one landing on the done cycle re-arms
      if (flush) flush_pend <= 1'b1;
    end
  end

  assign data              = bus.fifo_dout;
  assign bus.fifo_ren      = ren;
  assign bus.wr_req        = req_q;
  assign bus.wr_addr       = addr_q;
  assign bus.wr_len        = len_q;
  assign bus.wr_data       = data;
  assign bus.wr_data_valid = valid_q;
  assign flush_done        = done_q;
  assign busy              = (state != IDLE);
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_sdram_wr_fetch.sv
// Bench for sdram_wr_fetch: a default-region instance and a small wrapping
// region instance (base 4, 16 words) share one FIFO model and stimulus.
module tb_sdram_wr_fetch;

  logic clk;
  logic rst;
  logic flush;
  logic flush_done0, busy0, underrun0;
  logic flush_done1, busy1, underrun1;
  logic force_empty;
  int   pushed;
  int   popped;
  int   pop_cnt;
  int   valid_cnt;
  bit   prev_ren;
  int   checks;
  int   errors;

  sdram_wr_fetch_if bus0 ();
  sdram_wr_fetch_if bus1 ();

  sdram_wr_fetch dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .flush(flush),
    .flush_done(flush_done0), .busy(busy0), .underrun(underrun0)
  );

  sdram_wr_fetch #(.ADDR_BASE(4), .REGION_WORDS(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .flush(flush),
    .flush_done(flush_done1), .busy(busy1), .underrun(underrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data, occupancy count lagging by one cycle
  assign bus0.fifo_empty = (pushed == popped) || force_empty;
  always @(posedge clk) begin
    bus0.fifo_count <= 10'(pushed - popped);
    if (bus0.fifo_ren) begin
      bus0.fifo_dout <= 16'hA000 + 16'(popped);
      popped <= popped + 1;
    end
  end

  assign bus1.fifo_dout   = bus0.fifo_dout;
  assign bus1.fifo_empty  = bus0.fifo_empty;
  assign bus1.fifo_count  = bus0.fifo_count;
  assign bus1.wr_ack      = bus0.wr_ack;
  assign bus1.wr_data_req = bus0.wr_data_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // stream monitor: valid trails each pop by one cycle and carries the popped word
  always @(negedge clk) begin
    if (rst) check("ren_in_reset", 32'(bus0.fifo_ren), 0);
    check("valid_lag", 32'(bus0.wr_data_valid), 32'(prev_ren));
    if (bus0.wr_data_valid) begin
      check("wr_data", 32'(bus0.wr_data), 32'(16'hA000 + 16'(valid_cnt)));
      valid_cnt++;
    end
    if (bus0.fifo_ren) pop_cnt++;
    prev_ren = bus0.fifo_ren;
  end

  typedef struct {
    int load;
    bit do_flush;
    int ack_dly;
    bit gapped;
    bit inject_empty;
    bit quiet;
    int exp_addr0;
    int exp_addr1;
    int exp_len;
    int exp_next0;
    int exp_next1;
  } row_t;

  task automatic run_burst(input row_t r);
    int cyc;
    int p0;
    bit seen;
    pushed += r.load;
    if (r.do_flush) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    cyc = 0;
    while (!bus0.wr_req && cyc < 20) begin
      step();
      cyc++;
    end
    check("req_seen", 32'(bus0.wr_req), 1);
    check("wr_addr", 32'(bus0.wr_addr), r.exp_addr0);
    check("wrap_addr", 32'(bus1.wr_addr), r.exp_addr1);
    check("wr_len", 32'(bus0.wr_len), r.exp_len);
    repeat (r.ack_dly) step();
    check("req_hold", 32'(bus0.wr_req), 1);
    bus0.wr_ack = 1'b1;
    step();
    bus0.wr_ack = 1'b0;
    check("req_drop", 32'(bus0.wr_req), 0);
    p0  = pop_cnt;
    cyc = 0;
    while (pop_cnt - p0 < r.exp_len && cyc < 64) begin
      bus0.wr_data_req = r.gapped ? (cyc % 2 == 0) : 1'b1;
      force_empty = r.inject_empty && (cyc == 2);
      #1;
      if (force_empty) check("pop_blocked", 32'(bus0.fifo_ren), 0);
      step();
      cyc++;
    end
    bus0.wr_data_req = 1'b0;
    force_empty = 1'b0;
    check("pops", pop_cnt - p0, r.exp_len);
    check("last_valid", 32'(bus0.wr_data_valid), 1);
    check("busy_last", 32'(busy0), 1);
    step();
    check("next_addr", 32'(bus0.wr_addr), r.exp_next0);
    check("wrap_next", 32'(bus1.wr_addr), r.exp_next1);
    step();
    check("busy_settle", 32'(busy0), 1);
    step();
    check("busy_idle", 32'(busy0), 0);
    check("valid_total", valid_cnt, pop_cnt);
    if (r.do_flush) begin
      cyc = 0;
      while (!flush_done0 && cyc < 10) begin
        step();
        cyc++;
      end
      check("flush_done", 32'(flush_done0), 1);
      step();
      check("flush_done_pulse", 32'(flush_done0), 0);
    end
    if (r.quiet) begin
      seen = 1'b0;
      repeat (4) begin
        step();
        if (bus0.wr_req) seen = 1'b1;
      end
      check("no_extra_req", 32'(seen), 0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_addr", 32'(bus0.wr_addr), 0);
    check("rst_wrap_addr", 32'(bus1.wr_addr), 4);
    check("rst_wr_len", 32'(bus0.wr_len), 0);
    check("rst_wr_req", 32'(bus0.wr_req), 0);
    check("rst_valid", 32'(bus0.wr_data_valid), 0);
    check("rst_flush_done", 32'(flush_done0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_underrun", 32'(underrun0), 0);
    check("rst_ren", 32'(bus0.fifo_ren), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    row_t again;
    int p0;
    int cyc;
    rows[0] = '{8,  1'b0, 3, 1'b0, 1'b0, 1'b1,  0,  4, 8,  8, 12};
    rows[1] = '{16, 1'b0, 1, 1'b0, 1'b0, 1'b0,  8, 12, 8, 16,  4};
    rows[2] = '{0,  1'b0, 0, 1'b0, 1'b0, 1'b1, 16,  4, 8, 24, 12};
    rows[3] = '{3,  1'b1, 2, 1'b0, 1'b0, 1'b1, 24, 12, 3, 27, 15};
    rows[4] = '{8,  1'b0, 1, 1'b1, 1'b1, 1'b1, 27, 15, 8, 35,  7};
    again   = '{4,  1'b0, 2, 1'b0, 1'b0, 1'b1,  0,  4, 8,  8, 12};

    checks = 0;
    errors = 0;
    pushed = 0;
    popped = 0;
    pop_cnt = 0;
    valid_cnt = 0;
    prev_ren = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    force_empty = 1'b0;
    bus0.wr_ack = 1'b0;
    bus0.wr_data_req = 1'b0;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy0), 0);

    for (int i = 0; i < 5; i++) begin
      run_burst(rows[i]);
      if (i == 3) check("underrun_clear", 32'(underrun0), 0);
      if (i == 4) check("underrun_set", 32'(underrun0), 1);
    end
    repeat (3) step();
    check("underrun_sticky", 32'(underrun0), 1);

    // reset in the middle of a transfer, after four pops
    pushed += 8;
    cyc = 0;
    while (!bus0.wr_req && cyc < 20) begin
      step();
      cyc++;
    end
    check("mid_req", 32'(bus0.wr_req), 1);
    bus0.wr_ack = 1'b1;
    step();
    bus0.wr_ack = 1'b0;
    p0 = pop_cnt;
    bus0.wr_data_req = 1'b1;
    cyc = 0;
    while (pop_cnt - p0 < 4 && cyc < 20) begin
      step();
      cyc++;
    end
    check("mid_pops", pop_cnt - p0, 4);
    rst = 1'b1;
    #1;
    check("ren_gated", 32'(bus0.fifo_ren), 0);
    step();
    check_reset_outputs();
    step();
    check("rst_hold_pops", pop_cnt - p0, 4);
    rst = 1'b0;
    bus0.wr_data_req = 1'b0;
    run_burst(again);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
